jk_counter_bank: RTL and testbench
==================================

Name: jk_counter_bank

Overview:
- Parametrised successor to the single JK flip-flop: a WIDTH-bit register built from JK cells, with selectable operating mode.
- Modes are raw per-bit JK, modulo-N up count, modulo-N down count, and parallel load.
- Used as the general counter/state register in the sequential-circuit lab designs.
- Provides a combinational terminal-count flag and a registered wrap pulse for cascading.

Parameters:
- WIDTH, 4, register width in bits (1..16).
- MODULO, 2**WIDTH, count modulus; legal range 2..2**WIDTH; count range 0..MODULO-1.
- SATURATE, 0, 0 = wrap at range ends; 1 = stick at range ends.
- RESET_VALUE, 0, value of q after reset; must be < MODULO.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, 1, when 0 the register holds and wrap is cleared on the next edge.
- mode, input, 2, operating mode: 00 JK, 01 UP, 10 DOWN, 11 LOAD.
- j, input, WIDTH, per-bit J (JK mode only).
- k, input, WIDTH, per-bit K (JK mode only).
- d, input, WIDTH, parallel load data (LOAD mode only).
- q, output, WIDTH, register state.
- tc, output, 1, terminal count (combinational).
- wrap, output, 1, one-cycle registered pulse marking a wrap or saturation event.

Behaviour:
- Reset: while reset=1, q=RESET_VALUE and wrap=0 immediately, independent of clk. Release is synchronous to the next rising edge; the first update occurs on the first rising edge with reset=0.
- All state changes happen on the rising clk edge. Latency is 1 cycle from inputs to q and to wrap.
- enable=0: q holds, wrap<=0. mode, j, k and d are ignored.
- JK mode (enable=1, mode=00), per bit i:
  - j=0, k=0: hold.
  - j=1, k=0: set to 1.
  - j=0, k=1: clear to 0.
  - j=1, k=1: toggle.
  - MODULO is not applied, so q may leave 0..MODULO-1. wrap<=0.
- UP mode (mode=01):
  - q < MODULO-1: q<=q+1, wrap<=0.
  - q >= MODULO-1: q<=0 when SATURATE=0, or q<=MODULO-1 when SATURATE=1; wrap<=1 in both cases.
- DOWN mode (mode=10):
  - 0 < q <= MODULO-1: q<=q-1, wrap<=0.
  - q == 0: q<=MODULO-1 when SATURATE=0, or q<=0 when SATURATE=1; wrap<=1.
  - q > MODULO-1 (reachable only via JK mode): q<=MODULO-1, wrap<=0.
- LOAD mode (mode=11): q<=d when d < MODULO, otherwise q<=MODULO-1 (clamp). wrap<=0.
- tc = enable & ((mode==UP & q>=MODULO-1) | (mode==DOWN & q==0)). It is combinational, so it is asserted in the same cycle as the edge that causes wrap.
- wrap is high for exactly one cycle per wrap or saturation event.
  - Under SATURATE=1 with continuous counting at the range end, wrap stays high every cycle.
- Arithmetic: next-state math is done in WIDTH+1 bits so that MODULO=2**WIDTH fits without overflow.
- Implementation rule: the next-state value n is mapped to per-cell drives J=n&~q and K=~n&q. The counter is always realised through the JK cells, never as a plain D register.
- Reset mid-count: q returns to RESET_VALUE and wrap to 0 immediately. The count resumes from RESET_VALUE after release.

Decomposition:
- Shared package jk_pkg:
  - mode constants MODE_JK=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11.
  - a jk_mode_t 2-bit typedef.
- One sub-module, jk_cell:
  - a single JK flip-flop with clk and async active-high reset;
  - parameter RST_VAL (1 bit);
  - instantiated WIDTH times from a generate loop;
  - per-cell RST_VAL = RESET_VALUE[i].
- Next-state mux, clamping, tc and the wrap register live in the top module.

Test Plan (WIDTH=4, MODULO=10, SATURATE=0, RESET_VALUE=0 unless noted):
- reset=1 asserted mid-cycle while q=7 -> q=0 and wrap=0 before the next edge. After release, UP for 3 edges -> q=3.
- UP from q=8, enable=1, 2 edges -> q=9 with tc=1, then q=0 with wrap=1 for exactly one cycle. Then enable=0 -> q holds at 0 and wrap=0.
- DOWN from q=0 -> tc=1, then q=9 and wrap=1. Rerun with SATURATE=1 -> q stays 0 and wrap=1 each cycle.
- JK mode, q=0000, j=1010 k=0000 -> q=1010. Then j=1111 k=1111 -> q=0101. Then j=0000 k=0100 -> q=0001. Then j=0000 k=0000 -> hold at 0001.
- LOAD d=6 -> q=6. LOAD d=13 -> q=9 (clamp). JK to q=12, then DOWN -> q=9 and wrap=0. JK to q=12, then UP -> q=0 and wrap=1.
- Instance with WIDTH=3, MODULO=8, RESET_VALUE=5 -> q=5 after reset. UP from 7 -> q=0 and wrap=1, checking the no-overflow path at MODULO=2**WIDTH.

Source files
------------

// File: rtl/jk_pkg.sv
// jk_pkg: operating-mode type and mode encodings shared by the JK counter bank
package jk_pkg;
  typedef logic [1:0] jk_mode_t;
  localparam jk_mode_t MODE_JK   = 2'b00;
  localparam jk_mode_t MODE_UP   = 2'b01;
  localparam jk_mode_t MODE_DOWN = 2'b10;
  localparam jk_mode_t MODE_LOAD = 2'b11;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop, async active-high reset to RST_VAL (clk, reset, j, k -> q)
module jk_cell #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= RST_VAL;
    else       q <= (j & ~q) | (~k & q);
endmodule

// File: rtl/jk_counter_bank.sv
// jk_counter_bank: JK-cell register with JK/up/down/load modes (clk, reset, enable, mode, j, k, d -> q, tc, wrap)
module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULO      = 2 ** WIDTH,
  parameter bit SATURATE    = 1'b0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  jk_mode_t         mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  logic [WIDTH-1:0] n;
  logic up_end, dn_zero, dn_over, d_over;
  assign up_end  = {1'b0, q} >= MAX_X;
  assign dn_over = {1'b0, q} >  MAX_X;
  assign d_over  = {1'b0, d} >  MAX_X;
  assign dn_zero = q == '0;
  always_comb
    n = !enable            ? q :
        mode == MODE_JK    ? (j & ~q) | (~k & q) :
        mode == MODE_UP    ? (up_end ? (SATURATE ? MAX : '0) : q + ONE) :
        mode == MODE_DOWN  ? (dn_over ? MAX : dn_zero ? (SATURATE ? '0 : MAX) : q - ONE) :
                             (d_over ? MAX : d);
  assign tc = enable & ((mode == MODE_UP & up_end) | (mode == MODE_DOWN & dn_zero));
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(.RST_VAL(RESET_VALUE[i])) u_cell (
      .clk  (clk),
      .reset(reset),
      .j    (n[i] & ~q[i]),
      .k    (~n[i] & q[i]),
      .q    (q[i])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) wrap <= 1'b0;
    else       wrap <= tc;
endmodule

// File: tb/tb_jk_counter_bank.sv
// tb_jk_counter_bank: scoreboard bench for three jk_counter_bank configurations
module tb_jk_counter_bank;
  import jk_pkg::*;
  typedef struct {
    int         s;
    string      nm;
    logic [3:0] q;
    logic       w;
    logic       t;
  } exp_t;
  exp_t sb[$];
  logic clk = 1'b0;
  logic reset;
  logic [2:0] en;
  jk_mode_t md[3];
  logic [2:0][3:0] jv, kv, dv;
  logic [3:0] q0, q1;
  logic [2:0] q2;
  logic [2:0] tcv, wv;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  jk_counter_bank #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0), .RESET_VALUE(0)) u_d0 (
    .clk(clk), .reset(reset), .enable(en[0]), .mode(md[0]), .j(jv[0]), .k(kv[0]), .d(dv[0]),
    .q(q0), .tc(tcv[0]), .wrap(wv[0]));
  jk_counter_bank #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1), .RESET_VALUE(0)) u_d1 (
    .clk(clk), .reset(reset), .enable(en[1]), .mode(md[1]), .j(jv[1]), .k(kv[1]), .d(dv[1]),
    .q(q1), .tc(tcv[1]), .wrap(wv[1]));
  jk_counter_bank #(.WIDTH(3), .MODULO(8), .SATURATE(1'b0), .RESET_VALUE(5)) u_d2 (
    .clk(clk), .reset(reset), .enable(en[2]), .mode(md[2]), .j(jv[2][2:0]), .k(kv[2][2:0]), .d(dv[2][2:0]),
    .q(q2), .tc(tcv[2]), .wrap(wv[2]));
  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (sb.size() != 0) begin
      exp_t it;
      logic [3:0] aq;
      it = sb.pop_front();
      aq = it.s == 0 ? q0 : it.s == 1 ? q1 : {1'b0, q2};
      chk($sformatf("d%0d %s {q,wrap,tc}", it.s, it.nm), {aq, wv[it.s], tcv[it.s]}, {it.q, it.w, it.t});
    end
  task automatic step(input int s, input string nm, input logic e, input jk_mode_t m,
                      input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] dd,
                      input logic [3:0] eq, input logic ew, input logic et);
    en[s] = e; md[s] = m; jv[s] = jj; kv[s] = kk; dv[s] = dd;
    sb.push_back('{s, nm, eq, ew, et});
    @(negedge clk);
    #1;
    en[s] = 1'b0;
  endtask
  initial begin
    en = '0; jv = '0; kv = '0; dv = '0;
    for (int i = 0; i < 3; i++) md[i] = MODE_JK;
    reset = 1'b1;
    #7;
    chk("reset q0", {2'b0, q0}, 6'd0);
    chk("reset q2", {3'b0, q2}, 6'd5);
    chk("reset wraps", {3'b0, wv}, 6'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    step(0, "load7", 1, MODE_LOAD, 0, 0, 7, 7, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("midreset q0", {2'b0, q0}, 6'd0);
    chk("midreset wrap0", {5'b0, wv[0]}, 6'd0);
    chk("midreset q2", {3'b0, q2}, 6'd5);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    step(0, "up1", 1, MODE_UP, 0, 0, 0, 1, 0, 0);
    step(0, "up2", 1, MODE_UP, 0, 0, 0, 2, 0, 0);
    step(0, "up3", 1, MODE_UP, 0, 0, 0, 3, 0, 0);
    step(0, "load8", 1, MODE_LOAD, 0, 0, 8, 8, 0, 0);
    step(0, "up9", 1, MODE_UP, 0, 0, 0, 9, 0, 1);
    step(0, "upwrap", 1, MODE_UP, 0, 0, 0, 0, 1, 0);
    step(0, "hold", 0, MODE_UP, 0, 0, 0, 0, 0, 0);
    step(0, "dnwrap", 1, MODE_DOWN, 0, 0, 0, 9, 1, 0);
    step(0, "dn8", 1, MODE_DOWN, 0, 0, 0, 8, 0, 0);
    step(0, "load0", 1, MODE_LOAD, 0, 0, 0, 0, 0, 0);
    step(0, "jkset", 1, MODE_JK, 4'b1010, 4'b0000, 0, 4'b1010, 0, 0);
    step(0, "jktog", 1, MODE_JK, 4'b1111, 4'b1111, 0, 4'b0101, 0, 0);
    step(0, "jkclr", 1, MODE_JK, 4'b0000, 4'b0100, 0, 4'b0001, 0, 0);
    step(0, "jkhold", 1, MODE_JK, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0);
    step(0, "load6", 1, MODE_LOAD, 0, 0, 6, 6, 0, 0);
    step(0, "load13", 1, MODE_LOAD, 0, 0, 13, 9, 0, 0);
    step(0, "jk12a", 1, MODE_JK, 4'b1100, 4'b0011, 0, 12, 0, 0);
    step(0, "dnover", 1, MODE_DOWN, 0, 0, 0, 9, 0, 0);
    step(0, "jk12b", 1, MODE_JK, 4'b1100, 4'b0011, 0, 12, 0, 0);
    step(0, "upover", 1, MODE_UP, 0, 0, 0, 0, 1, 0);
    step(1, "satdn1", 1, MODE_DOWN, 0, 0, 0, 0, 1, 1);
    step(1, "satdn2", 1, MODE_DOWN, 0, 0, 0, 0, 1, 1);
    step(1, "load9", 1, MODE_LOAD, 0, 0, 9, 9, 0, 0);
    step(1, "satup1", 1, MODE_UP, 0, 0, 0, 9, 1, 1);
    step(1, "satup2", 1, MODE_UP, 0, 0, 0, 9, 1, 1);
    step(1, "sathold", 0, MODE_UP, 0, 0, 0, 9, 0, 0);
    step(2, "load7", 1, MODE_LOAD, 0, 0, 7, 7, 0, 0);
    step(2, "upwrap", 1, MODE_UP, 0, 0, 0, 0, 1, 0);
    step(2, "up1", 1, MODE_UP, 0, 0, 0, 1, 0, 0);
    step(2, "dn0", 1, MODE_DOWN, 0, 0, 0, 0, 0, 1);
    step(2, "dnwrap", 1, MODE_DOWN, 0, 0, 0, 7, 1, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
